fmr_replicator: RTL and testbench

Transmit-side front end of the five-lane modular-redundancy path. It registers a single-bit data stream into five identical lanes `a`..`e`, which feed the 5-input majority voter directly. It also contains a deterministic fault-injection controller that can corrupt one chosen lane for a programmed number of data beats. This lets the voter's masking behaviour be exercised in-system.

---
 rtl/fmr_pkg.sv | 21 ++
 rtl/fmr_replicator_if.sv | 32 +++
 rtl/fmr_inj_ctrl.sv | 80 ++++++++
 rtl/fmr_replicator.sv | 65 ++++++
 tb/tb_fmr_replicator.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/fmr_pkg.sv
// Shared types and constants for the five-lane modular-redundancy front end.
package fmr_pkg;

    localparam int FMR_LANES = 5;

    typedef enum logic [1:0] {
        FLIP   = 2'b00,
        STUCK0 = 2'b01,
        STUCK1 = 2'b10,
        RSVD   = 2'b11
    } inj_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        INJECT = 2'b01,
        DONE   = 2'b10
    } inj_state_t;

    typedef logic [2:0] lane_idx_t;

endpackage

// File: rtl/fmr_replicator_if.sv
// Data and injection-control bundle of the replicator; master drives requests, slave is the block.
interface fmr_replicator_if
    import fmr_pkg::*;
#(
    parameter int INJ_LEN_W = 8
);
    logic                 din;
    logic                 din_valid;
    logic                 inj_start;
    lane_idx_t            inj_lane;
    logic [1:0]           inj_mode;
    logic [INJ_LEN_W-1:0] inj_len;
    logic                 a;
    logic                 b;
    logic                 c;
    logic                 d;
    logic                 e;
    logic                 lane_valid;
    logic                 inj_busy;
    logic                 inj_done;
    logic                 inj_err;

    modport master (
        output din, din_valid, inj_start, inj_lane, inj_mode, inj_len,
        input  a, b, c, d, e, lane_valid, inj_busy, inj_done, inj_err
    );

    modport slave (
        input  din, din_valid, inj_start, inj_lane, inj_mode, inj_len,
        output a, b, c, d, e, lane_valid, inj_busy, inj_done, inj_err
    );
endinterface

// File: rtl/fmr_inj_ctrl.sv
// Fault-injection controller: accepts/rejects requests, latches the target and counts corrupted beats.
module fmr_inj_ctrl
    import fmr_pkg::*;
#(
    parameter int INJ_LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_din_valid,
    input  logic                 i_inj_start,
    input  lane_idx_t            i_inj_lane,
    input  logic [1:0]           i_inj_mode,
    input  logic [INJ_LEN_W-1:0] i_inj_len,
    output logic [FMR_LANES-1:0] o_corrupt_en,
    output inj_mode_t            o_mode,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    inj_state_t           r_state;
    lane_idx_t            r_lane;
    inj_mode_t            r_mode;
    logic [INJ_LEN_W-1:0] r_cnt;
    logic                 r_err;
    logic                 w_req_ok;

    assign w_req_ok = (i_inj_lane <= 3'd4) && (i_inj_mode != 2'b11) && (i_inj_len != '0);

    // FSM, latched request fields and remaining-beat counter; only beats in INJECT count down
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_lane  <= '0;
            r_mode  <= FLIP;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= i_inj_start && ((r_state != IDLE) || !w_req_ok);
            case (r_state)
                IDLE: begin
                    if (i_inj_start && w_req_ok) begin
                        r_state <= INJECT;
                        r_lane  <= i_inj_lane;
                        r_mode  <= inj_mode_t'(i_inj_mode);
                        r_cnt   <= i_inj_len;
                    end
                end
                INJECT: begin
                    if (i_din_valid) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == INJ_LEN_W'(1)) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // One-hot corrupt enable on the latched lane while an injection is running
    always_comb begin
        o_corrupt_en = '0;
        for (int i = 0; i < FMR_LANES; i++) begin
            o_corrupt_en[i] = (r_state == INJECT) && (r_lane == lane_idx_t'(i));
        end
    end

    assign o_mode = r_mode;
    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == DONE);
    assign o_err  = r_err;

endmodule

// File: rtl/fmr_replicator.sv
// Five-lane replicator with a corruption mux on each lane driven by the injection controller.
module fmr_replicator
    import fmr_pkg::*;
#(
    parameter int INJ_LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    fmr_replicator_if.slave   bus
);

    logic [FMR_LANES-1:0] r_lane;
    logic                 r_lane_valid;
    logic [FMR_LANES-1:0] w_corrupt_en;
    inj_mode_t            w_mode;

    function automatic logic corrupt(input logic d, input inj_mode_t m);
        case (m)
            FLIP:    corrupt = ~d;
            STUCK0:  corrupt = 1'b0;
            STUCK1:  corrupt = 1'b1;
            default: corrupt = d;
        endcase
    endfunction

    fmr_inj_ctrl #(
        .INJ_LEN_W (INJ_LEN_W)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .i_din_valid  (bus.din_valid),
        .i_inj_start  (bus.inj_start),
        .i_inj_lane   (bus.inj_lane),
        .i_inj_mode   (bus.inj_mode),
        .i_inj_len    (bus.inj_len),
        .o_corrupt_en (w_corrupt_en),
        .o_mode       (w_mode),
        .o_busy       (bus.inj_busy),
        .o_done       (bus.inj_done),
        .o_err        (bus.inj_err)
    );

    // Lane registers load din (or its corrupted form on the target lane) on every beat, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane       <= '0;
            r_lane_valid <= 1'b0;
        end else begin
            r_lane_valid <= bus.din_valid;
            if (bus.din_valid) begin
                for (int i = 0; i < FMR_LANES; i++) begin
                    r_lane[i] <= w_corrupt_en[i] ? corrupt(bus.din, w_mode) : bus.din;
                end
            end
        end
    end

    assign bus.a          = r_lane[0];
    assign bus.b          = r_lane[1];
    assign bus.c          = r_lane[2];
    assign bus.d          = r_lane[3];
    assign bus.e          = r_lane[4];
    assign bus.lane_valid = r_lane_valid;

endmodule

// File: tb/tb_fmr_replicator.sv
// Directed bench for fmr_replicator with a beat-level reference model and per-cycle compare.
module tb_fmr_replicator;

    logic clk;
    logic rst;

    fmr_replicator_if #(.INJ_LEN_W(8)) bus ();

    fmr_replicator #(.INJ_LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: remaining corrupted beats plus latched target, updated per clock edge
    logic [4:0] m_lanes = '0;
    logic       e_lv = 0, e_busy = 0, e_done = 0, e_err = 0;
    int         m_rem = 0;
    int         m_lane = 0;
    int         m_mode = 0;

    always @(posedge clk) begin
        logic rej;
        logic fin;
        if (rst) begin
            m_lanes = '0; m_rem = 0;
            e_lv = 0; e_busy = 0; e_done = 0; e_err = 0;
        end else begin
            rej = bus.inj_start && (e_busy || bus.inj_lane > 4 || bus.inj_mode == 2'd3 || bus.inj_len == 0);
            fin = 1'b0;
            if (bus.din_valid) begin
                m_lanes = {5{bus.din}};
                if (m_rem > 0) begin
                    m_lanes[m_lane] = (m_mode == 0) ? ~bus.din : (m_mode == 1) ? 1'b0 : 1'b1;
                    m_rem = m_rem - 1;
                    if (m_rem == 0) fin = 1'b1;
                end
            end
            if (bus.inj_start && !rej) begin
                m_lane = int'(bus.inj_lane);
                m_mode = int'(bus.inj_mode);
                m_rem  = int'(bus.inj_len);
            end
            e_lv   = bus.din_valid;
            e_done = fin;
            e_err  = rej;
            e_busy = (m_rem > 0) || fin;
        end
    end

    // Compare all outputs against the model every cycle
    always @(negedge clk) begin
        logic [8:0] got, want;
        if (chk_en) begin
            got  = {bus.e, bus.d, bus.c, bus.b, bus.a, bus.lane_valid, bus.inj_busy, bus.inj_done, bus.inj_err};
            want = {m_lanes, e_lv, e_busy, e_done, e_err};
            n_vec++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t got e..a,lv,busy,done,err=%b want %b", $time, got, want);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic dv, input logic dn, input logic st = 1'b0,
                        input logic [2:0] ln = 3'd0, input logic [1:0] md = 2'd0,
                        input logic [7:0] len = 8'd0);
        bus.din_valid = dv;
        bus.din       = dn;
        bus.inj_start = st;
        bus.inj_lane  = ln;
        bus.inj_mode  = md;
        bus.inj_len   = len;
        @(negedge clk);
    endtask

    function automatic logic [8:0] outs();
        return {bus.e, bus.d, bus.c, bus.b, bus.a, bus.lane_valid, bus.inj_busy, bus.inj_done, bus.inj_err};
    endfunction

    initial begin
        int corrupted;
        int done_idx;
        logic dn;
        rst = 1'b1;
        step(1, 1, 1, 0, 0, 4);
        chk_en = 1'b1;
        lit("reset_outputs", 32'(outs()), 32'h0);
        step(0, 0);
        rst = 1'b0;

        // Clean replication
        for (int i = 0; i < 16; i++) begin
            step(1, i[0]);
            lit("clean_lanes", 32'({bus.a, bus.b, bus.c, bus.d, bus.e}), i[0] ? 32'h1f : 32'h0);
            lit("clean_busy", 32'(bus.inj_busy), 32'h0);
        end
        step(0, 0);
        lit("idle_lv", 32'(bus.lane_valid), 32'h0);

        // Flip on lane c, length 3
        step(0, 0, 1, 3'd2, 2'd0, 8'd3);
        lit("flip_busy", 32'(bus.inj_busy), 32'h1);
        step(1, 1); lit("flip_c1", 32'(bus.c), 32'h0); lit("flip_a1", 32'(bus.a), 32'h1);
        step(1, 1); lit("flip_c2", 32'(bus.c), 32'h0);
        step(1, 0); lit("flip_c3", 32'(bus.c), 32'h1); lit("flip_done", 32'(bus.inj_done), 32'h1);
        step(1, 1); lit("flip_c4", 32'(bus.c), 32'h1); lit("flip_nodone", 32'(bus.inj_done), 32'h0);
        step(0, 0);

        // Stuck-1 on lane e with gaps
        step(0, 0, 1, 3'd4, 2'd2, 8'd2);
        step(1, 0); lit("s1_e1", 32'(bus.e), 32'h1); lit("s1_a1", 32'(bus.a), 32'h0);
        step(0, 0); lit("s1_gap_lv", 32'(bus.lane_valid), 32'h0);
        step(0, 0); lit("s1_gap_busy", 32'(bus.inj_busy), 32'h1);
        step(1, 0); lit("s1_e2", 32'(bus.e), 32'h1); lit("s1_done", 32'(bus.inj_done), 32'h1);
        step(1, 0); lit("s1_e3", 32'(bus.e), 32'h0);
        step(0, 0);

        // Rejections
        step(0, 0, 1, 3'd5, 2'd0, 8'd3); lit("rej_lane", 32'({bus.inj_err, bus.inj_busy}), 32'h2);
        step(0, 0, 1, 3'd0, 2'd3, 8'd3); lit("rej_mode", 32'({bus.inj_err, bus.inj_busy}), 32'h2);
        step(0, 0, 1, 3'd0, 2'd0, 8'd0); lit("rej_len", 32'({bus.inj_err, bus.inj_busy}), 32'h2);
        step(1, 1); lit("rej_clean", 32'({bus.a, bus.b, bus.c, bus.d, bus.e}), 32'h1f);
        step(0, 0, 1, 3'd1, 2'd1, 8'd2);
        step(1, 1, 1, 3'd3, 2'd1, 8'd4);
        lit("busy_rej_err", 32'(bus.inj_err), 32'h1); lit("busy_rej_b", 32'(bus.b), 32'h0);
        lit("busy_rej_d", 32'(bus.d), 32'h1);
        step(1, 1); lit("busy_b2", 32'(bus.b), 32'h0); lit("busy_done", 32'(bus.inj_done), 32'h1);
        step(1, 1); lit("busy_b3", 32'(bus.b), 32'h1); lit("busy_d3", 32'(bus.d), 32'h1);
        step(0, 0);

        // Reset mid-injection
        step(0, 0, 1, 3'd0, 2'd0, 8'd5);
        step(1, 1); lit("rstmid_a", 32'(bus.a), 32'h0);
        rst = 1'b1;
        step(1, 1); lit("rstmid_zero", 32'(outs()), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1, 1);
            lit("post_rst", 32'({bus.a, bus.inj_done, bus.inj_busy}), 32'h4);
        end
        step(0, 0);

        // Maximum length flip on lane a
        step(0, 0, 1, 3'd0, 2'd0, 8'd255);
        corrupted = 0;
        done_idx  = -1;
        for (int i = 0; i < 262; i++) begin
            dn = i[0] ^ i[3];
            step(1, dn);
            if (bus.a != bus.b) corrupted++;
            if (bus.inj_done) done_idx = i;
        end
        lit("max_count", 32'(corrupted), 32'd255);
        lit("max_done_idx", 32'(done_idx), 32'd254);
        lit("max_idle", 32'(bus.inj_busy), 32'h0);
        step(0, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
